// File: rtl/gigatron_arith_pkg.sv
// Shared arithmetic definitions for the nibble-serial adder path:
// sequencer states, slice width and the signed-overflow rule.
package gigatron_arith_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arith_state_t;

    // Overflow when both operands share a sign and the result sign differs.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_x74xx283.sv
// 4-bit binary full adder with fast carry, pin-equivalent to the 74xx283.
module x74xx283 (
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic a4,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    input  logic b4,
    input  logic c0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic s4,
    output logic c4
);

    logic p1, p2, p3, p4;
    logic g1, g2, g3, g4;
    logic c1, c2, c3;

    assign p1 = a1 ^ b1;
    assign p2 = a2 ^ b2;
    assign p3 = a3 ^ b3;
    assign p4 = a4 ^ b4;
    assign g1 = a1 & b1;
    assign g2 = a2 & b2;
    assign g3 = a3 & b3;
    assign g4 = a4 & b4;

    // Flattened lookahead terms, as in the TTL part.
    assign c1 = g1 | (p1 & c0);
    assign c2 = g2 | (p2 & g1) | (p2 & p1 & c0);
    assign c3 = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & c0);
    assign c4 = g4 | (p4 & g3) | (p4 & p3 & g2) | (p4 & p3 & p2 & g1)
              | (p4 & p3 & p2 & p1 & c0);

    assign s1 = p1 ^ c0;
    assign s2 = p2 ^ c1;
    assign s3 = p3 ^ c2;
    assign s4 = p4 ^ c3;

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequenced through a single 4-bit adder slice,
// least-significant nibble first, with valid/ready on both sides.
module nibble_serial_adder_ctrl
    import gigatron_arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    arith_state_t     state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] bx_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                c_out;

    assign a_nib = a_reg[idx*NIBBLE_W +: NIBBLE_W];
    assign b_nib = bx_reg[idx*NIBBLE_W +: NIBBLE_W];

    x74xx283 u_slice (
        .a1 (a_nib[0]),
        .a2 (a_nib[1]),
        .a3 (a_nib[2]),
        .a4 (a_nib[3]),
        .b1 (b_nib[0]),
        .b2 (b_nib[1]),
        .b3 (b_nib[2]),
        .b4 (b_nib[3]),
        .c0 (carry),
        .s1 (s_nib[0]),
        .s2 (s_nib[1]),
        .s3 (s_nib[2]),
        .s4 (s_nib[3]),
        .c4 (c_out)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            a_reg     <= '0;
            bx_reg    <= '0;
            carry     <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1, so cin is overridden.
                        a_reg    <= a;
                        bx_reg   <= b ^ {WIDTH{op_sub}};
                        carry    <= op_sub | cin;
                        idx      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sum[idx*NIBBLE_W +: NIBBLE_W] <= s_nib;
                    carry <= c_out;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout      <= c_out;
                        ovf       <= signed_ovf(a_reg[WIDTH-1], bx_reg[WIDTH-1], s_nib[NIBBLE_W-1]);
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit 74xx283-equivalent adder slice, least-significant nibble first.
- Carry is registered between nibbles.
- Used in the Gigatron-family testbench/FPGA builds where wide arithmetic is built from the 4-bit TTL adder model instead of a synthesized wide adder.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4. Elaboration error otherwise.
- NIBBLES, WIDTH/4, derived localparam; number of adder passes.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and op are presented.
- in_ready  output  1  block can accept a new operation.
- op_sub  input  1  0 = A+B+CIN; 1 = A-B (B inverted, carry-in forced 1, cin ignored).
- cin  input  1  carry in for add.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result held valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  final carry out; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, active-high), effective immediately:
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - sum=0; cout=0; ovf=0.
  - Operand and carry registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at posedge: capture a, b^{WIDTH{op_sub}}, carry=op_sub?1:cin.
  - Set nibble index idx=0 and go to RUN.
  - sum is not cleared on accept; it is only guaranteed while out_valid=1.
- RUN:
  - in_ready=0.
  - Each cycle, slice inputs are A[idx*4+:4], Bx[idx*4+:4], carry.
  - At posedge: write the slice sum into sum[idx*4+:4], carry <= slice COUT, idx <= idx+1.
  - When idx==NIBBLES-1:
    - cout <= slice COUT.
    - ovf <= (A msb == Bx msb) && (slice S3 != A msb).
    - Go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are stable.
  - On out_ready at posedge: go to IDLE with out_valid=0.
  - Holds indefinitely while out_ready=0.
- Latency: accept edge k gives out_valid high after edge k+NIBBLES (WIDTH=16: 4 cycles).
- Throughput: one op per NIBBLES+2 cycles minimum, since in_ready is asserted only in IDLE (one bubble).
- in_valid while not IDLE: ignored; operands are not sampled.
- op_sub/cin changes after accept: no effect.
- WIDTH=4: a single RUN cycle.
- Reset mid-RUN or mid-DONE: the operation is aborted and no out_valid is produced.
- All arithmetic is modulo 2^WIDTH; carry out of the top nibble appears only on cout.

Decomposition:
- Shared package gigatron_arith_pkg holds:
  - the state enum typedef (IDLE/RUN/DONE);
  - the NIBBLE_W=4 constant;
  - a function computing signed overflow from the msbs.
- Sub-module: reuse the existing x74xx283 slice, instantiated exactly once, with pin-level connections; no behavioural '+' in this block.
- Index counter width is $clog2(NIBBLES) with a minimum of 1.

Test Plan:
- WIDTH=16, add, a=0xFFFF, b=0x0001, cin=0 -> out_valid exactly 4 cycles after accept; sum=0x0000, cout=1, ovf=0.
- Add, a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
- Add, a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- op_sub=1, a=0x0005, b=0x0007, cin=1 (must be ignored) -> sum=0xFFFE, cout=0, ovf=0.
- op_sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and different operands -> sum/cout/ovf unchanged and in_ready=0 throughout. Then pulse out_ready -> IDLE next cycle, and the new op is accepted on the following edge.
- Reset asserted asynchronously in RUN after 2 nibbles:
  - outputs immediately at reset values; in_ready=1, no out_valid.
  - A subsequent op 0x00FF+0x0001 -> sum=0x0100.
